// File: rtl/acc_unit.sv
// Accumulator/E-register stage around the combinational ALU: holds AC, DR and E and
// runs a three-state accept/execute/write-back sequence with a valid/ready handshake.
module acc_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  bus_in,
  input  logic              dr_ld,
  input  logic              op_valid,
  input  logic [CODE_W-1:0] op_code,
  output logic              op_ready,
  output logic [WIDTH-1:0]  alu_ac,
  output logic [WIDTH-1:0]  alu_dr,
  output logic [CODE_W-1:0] alu_code,
  output logic              alu_ei,
  input  logic [WIDTH-1:0]  alu_dataout,
  input  logic              alu_eo,
  output logic [WIDTH-1:0]  ac_out,
  output logic [WIDTH-1:0]  dr_out,
  output logic              e_out,
  output logic              busy,
  output logic              done,
  output logic              ac_zero,
  output logic              ac_neg
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ac_q, ac_d;
  logic [WIDTH-1:0]   dr_q, dr_d;
  logic               e_q, e_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               reo_q, reo_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    e_d     = e_q;
    code_d  = code_q;
    res_d   = res_q;
    reo_d   = reo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A same-cycle load and accept both land, so EXEC sees the new DR.
        if (dr_ld) dr_d = bus_in;
        if (op_valid) begin
          code_d  = op_code;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = alu_dataout;
        reo_d   = alu_eo;
        state_d = StWb;
      end
      StWb: begin
        ac_d    = res_q;
        e_d     = reo_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ac_q    <= '0;
      dr_q    <= '0;
      e_q     <= 1'b0;
      code_q  <= '0;
      res_q   <= '0;
      reo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
      code_q  <= code_d;
      res_q   <= res_d;
      reo_q   <= reo_d;
      done_q  <= done_d;
    end
  end

  assign op_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign alu_ac   = ac_q;
  assign alu_dr   = dr_q;
  assign alu_code = code_q;
  assign alu_ei   = e_q;
  assign ac_out   = ac_q;
  assign dr_out   = dr_q;
  assign e_out    = e_q;
  assign ac_zero  = (ac_q == '0);
  assign ac_neg   = ac_q[WIDTH-1];

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: directed scenarios plus random traffic, all
// compared against a transaction-level model with an adder stub as the ALU.
module tb_acc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        dr_ld;
  logic        op_valid;
  logic [3:0]  op_code;
  logic        op_ready;
  logic [15:0] alu_ac, alu_dr, alu_dataout, ac_out, dr_out;
  logic [3:0]  alu_code;
  logic        alu_ei, alu_eo, e_out, busy, done, ac_zero, ac_neg;

  always #5 clk = ~clk;

  acc_unit #(.WIDTH(16), .CODE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_in      (bus_in),
    .dr_ld       (dr_ld),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_ready    (op_ready),
    .alu_ac      (alu_ac),
    .alu_dr      (alu_dr),
    .alu_code    (alu_code),
    .alu_ei      (alu_ei),
    .alu_dataout (alu_dataout),
    .alu_eo      (alu_eo),
    .ac_out      (ac_out),
    .dr_out      (dr_out),
    .e_out       (e_out),
    .busy        (busy),
    .done        (done),
    .ac_zero     (ac_zero),
    .ac_neg      (ac_neg)
  );

  // ALU stub: add with carry-out into E.
  assign {alu_eo, alu_dataout} = {1'b0, alu_ac} + {1'b0, alu_dr};

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Transaction-level model: an accepted op is a pending write due two edges later.
  logic [15:0] m_ac, m_dr, pend_ac;
  logic        m_e, m_done, pend, pend_e;
  logic [3:0]  m_code;
  int          pend_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [16:0] sum;
    if (rst) begin
      m_ac = '0; m_dr = '0; m_e = 1'b0; m_code = '0; m_done = 1'b0; pend = 1'b0;
      pend_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          m_ac = pend_ac; m_e = pend_e; m_done = 1'b1; pend = 1'b0;
        end
      end else begin
        if (dr_ld) m_dr = bus_in;
        if (op_valid) begin
          m_code = op_code;
          sum = {1'b0, m_ac} + {1'b0, m_dr};
          pend_ac = sum[15:0]; pend_e = sum[16]; pend = 1'b1; pend_cnt = 2;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ac_out", ac_out, m_ac);
    chk("alu_ac", alu_ac, m_ac);
    chk("dr_out", dr_out, m_dr);
    chk("alu_dr", alu_dr, m_dr);
    chk("e_out", e_out, m_e);
    chk("alu_ei", alu_ei, m_e);
    chk("alu_code", alu_code, m_code);
    chk("op_ready", op_ready, !pend);
    chk("busy", busy, pend);
    chk("done", done, m_done);
    chk("ac_zero", ac_zero, m_ac == 16'h0);
    chk("ac_neg", ac_neg, m_ac[15]);
  endtask

  task automatic step(input logic r, input logic v, input logic l, input logic [15:0] b,
                      input logic [3:0] c);
    rst = r; op_valid = v; dr_ld = l; bus_in = b; op_code = c;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  int acc_cyc[$];

  initial begin
    m_ac = '0; m_dr = '0; m_e = 1'b0; m_code = '0; m_done = 1'b0; pend = 1'b0;
    pend_ac = '0; pend_e = 1'b0; pend_cnt = 0;
    rst = 1'b1; op_valid = 1'b0; dr_ld = 1'b0; bus_in = '0; op_code = '0;

    // Reset held two cycles, with noise on the inputs it must override.
    step(1'b1, 1'b1, 1'b1, 16'hBEEF, 4'h7);
    step(1'b1, 1'b0, 0, 16'h0, 4'h0);
    chk("rst_ac", ac_out, 16'h0);
    chk("rst_dr", dr_out, 16'h0);
    chk("rst_zero", ac_zero, 1'b1);
    chk("rst_ready", op_ready, 1'b1);

    // Load and add.
    step(1'b0, 1'b0, 1'b1, 16'h0001, 4'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h1);
    chk("ld_exec_dr", alu_dr, 16'h0001);
    chk("ld_exec_code", alu_code, 4'h1);
    idle(1);
    chk("ld_wb_nodone", done, 1'b0);
    idle(1);
    chk("ld_ac", ac_out, 16'h0001);
    chk("ld_done", done, 1'b1);
    idle(1);
    chk("ld_done_pulse", done, 1'b0);

    // Carry: AC=1 + 0xFFFE = 0xFFFF, then + 1 wraps to 0 with E set.
    step(1'b0, 1'b1, 1'b1, 16'hFFFE, 4'h1);
    idle(3);
    chk("cy_ffff", ac_out, 16'hFFFF);
    chk("cy_neg", ac_neg, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0001, 4'h2);
    idle(3);
    chk("cy_ac", ac_out, 16'h0000);
    chk("cy_e", e_out, 1'b1);
    chk("cy_zero", ac_zero, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h3);
    chk("cy_ei", alu_ei, 1'b1);
    idle(3);

    // Busy gating: op_valid and dr_ld held high; accepts every third cycle.
    step(1'b0, 1'b0, 1'b1, 16'h0005, 4'h0);
    acc_cyc.delete();
    for (int i = 0; i < 7; i++) begin
      if (op_ready) acc_cyc.push_back(cyc);
      step(1'b0, 1'b1, (i == 0) ? 1'b0 : 1'b1, 16'h1234, 4'h4);
      if (i == 0) chk("gate_dr_exec", dr_out, 16'h0005);
      if (i == 1) chk("gate_dr_wb", dr_out, 16'h0005);
    end
    chk("gate_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("gate_space1", acc_cyc[1] - acc_cyc[0], 3);
      chk("gate_space2", acc_cyc[2] - acc_cyc[1], 3);
    end
    idle(3);

    // Simultaneous load and accept.
    step(1'b0, 1'b1, 1'b1, 16'h4000, 4'h5);
    chk("sim_exec_dr", alu_dr, 16'h4000);
    idle(3);

    // Reset in WB with a nonzero pending result.
    step(1'b0, 1'b1, 1'b1, 16'h0F0F, 4'h6);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("mid_ac", ac_out, 16'h0);
    chk("mid_done", done, 1'b0);
    chk("mid_ready", op_ready, 1'b1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           16'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
